// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encodings, opcode
// constants, register-destination encodings and the opcode classifier.
package multicycle_ctrl_pkg;

    // State encoding as seen on state_o.
    localparam int unsigned StateW = 3;
    localparam logic [StateW-1:0] StFetch  = 3'd0;
    localparam logic [StateW-1:0] StDecode = 3'd1;
    localparam logic [StateW-1:0] StExec   = 3'd2;
    localparam logic [StateW-1:0] StMem    = 3'd3;
    localparam logic [StateW-1:0] StWb     = 3'd4;
    localparam logic [StateW-1:0] StHalt   = 3'd5;
    localparam logic [StateW-1:0] StErr    = 3'd6;

    // Architectural opcodes (5-bit field).
    localparam int unsigned OpBaseW = 5;
    localparam logic [OpBaseW-1:0] OpHalt  = 5'b00000;
    localparam logic [OpBaseW-1:0] OpNop   = 5'b00001;
    localparam logic [OpBaseW-1:0] OpSt    = 5'b10000;
    localparam logic [OpBaseW-1:0] OpLd    = 5'b10001;
    localparam logic [OpBaseW-1:0] OpRtype = 5'b11011;
    // ALU-immediate group is 010xx; the low two bits select the operation.
    localparam logic [2:0]         OpAluImmPrefix = 3'b010;

    // reg_dst encodings.
    localparam logic [1:0] RegDstI  = 2'b00;
    localparam logic [1:0] RegDstR  = 2'b01;
    localparam logic [1:0] RegDstR7 = 2'b10;

    typedef enum logic [2:0] {
        ClsHalt,
        ClsNop,
        ClsAluImm,
        ClsRtype,
        ClsSt,
        ClsLd,
        ClsIllegal
    } op_class_e;

    function automatic op_class_e classify(input logic [OpBaseW-1:0] op);
        op_class_e cls;
        if (op == OpHalt) begin
            cls = ClsHalt;
        end else if (op == OpNop) begin
            cls = ClsNop;
        end else if (op == OpSt) begin
            cls = ClsSt;
        end else if (op == OpLd) begin
            cls = ClsLd;
        end else if (op == OpRtype) begin
            cls = ClsRtype;
        end else if (op[4:2] == OpAluImmPrefix) begin
            cls = ClsAluImm;
        end else begin
            cls = ClsIllegal;
        end
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory-side bus of the multicycle controller.
//   opcode, lower_two : instruction word fields returned by memory
//   mem_ready         : completion strobe for the outstanding fetch/load/store
//   mem_read/mem_write: request lines, held until mem_ready
// master = controller, slave = memory model.
interface multicycle_ctrl_if #(
    parameter int unsigned OPCODE_W = 5,
    parameter int unsigned FUNC_W   = 2
) ();

    logic [OPCODE_W-1:0] opcode;
    logic [FUNC_W-1:0]   lower_two;
    logic                mem_ready;
    logic                mem_read;
    logic                mem_write;

    modport master (
        input  opcode,
        input  lower_two,
        input  mem_ready,
        output mem_read,
        output mem_write
    );

    modport slave (
        output opcode,
        output lower_two,
        output mem_ready,
        input  mem_read,
        input  mem_write
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for memory handshakes.
//   clk, rst     : clock, asynchronous active-high reset
//   start_i      : the FSM enters a waiting state next cycle; clear the count
//   active_i     : the FSM is currently waiting on mem_ready
//   mem_ready_i  : memory completion strobe
//   timeout_o    : this cycle is the MEM_TIMEOUT-th consecutive wait without
//                  mem_ready; a ready in that same cycle still wins
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15  // 1..255
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic active_i,
    input  logic mem_ready_i,
    output logic timeout_o
);

    localparam logic [7:0] Limit = 8'(MEM_TIMEOUT);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = '0;
        end else if (active_i && !mem_ready_i && (count_q != Limit)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the misses seen so far; this cycle's miss would reach Limit.
    assign timeout_o = active_i && !mem_ready_i && (count_q >= (Limit - 8'd1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
//   clk, rst      : clock, asynchronous active-high reset
//   bus (master)  : memory requests, mem_ready, instruction opcode/lower_two
//   ir_write      : latch instruction register (FETCH, on mem_ready)
//   pc_write      : advance PC (FETCH, on mem_ready)
//   alu_op, alu_src_1, alu_src_2 : EXEC controls
//   alu_func      : captured lower_two, handed to ALU decode during EXEC
//   mem_to_reg, reg_write, reg_dst : WB controls
//   state_o       : current state encoding
//   halt, err     : sticky terminal-state flags
// OPCODE_W must be at least 5; opcode bits above bit 4 must be zero.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 5,
    parameter int unsigned FUNC_W      = 2,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_ctrl_if.master     bus,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  alu_op,
    output logic                  alu_src_1,
    output logic                  alu_src_2,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic [1:0]            reg_dst,
    output logic [FUNC_W-1:0]     alu_func,
    output logic [StateW-1:0]     state_o,
    output logic                  halt,
    output logic                  err
);

    logic [StateW-1:0]   state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q;
    logic [FUNC_W-1:0]   func_q;
    op_class_e           op_class;
    logic                capture;
    logic                wait_active;
    logic                wait_start;
    logic                timeout;

    // Classification of the captured opcode.
    always_comb begin
        if ((opcode_q >> OpBaseW) != '0) begin
            op_class = ClsIllegal;
        end else begin
            op_class = classify(opcode_q[OpBaseW-1:0]);
        end
    end

    assign capture     = (state_q == StFetch) && bus.mem_ready;
    assign wait_active = (state_q == StFetch) || (state_q == StMem);
    // Clear on every entry to a waiting state, including MEM -> FETCH.
    assign wait_start  = ((state_d == StFetch) || (state_d == StMem)) && (state_d != state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .start_i     (wait_start),
        .active_i    (wait_active),
        .mem_ready_i (bus.mem_ready),
        .timeout_o   (timeout)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (bus.mem_ready) begin
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StErr;
                end
            end
            StDecode: begin
                unique case (op_class)
                    ClsHalt:    state_d = StHalt;
                    ClsNop:     state_d = StFetch;
                    ClsIllegal: state_d = StErr;
                    default:    state_d = StExec;
                endcase
            end
            StExec: begin
                if ((op_class == ClsLd) || (op_class == ClsSt)) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (bus.mem_ready) begin
                    state_d = (op_class == ClsLd) ? StWb : StFetch;
                end else if (timeout) begin
                    state_d = StErr;
                end
            end
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            StErr:   state_d = StErr;
            default: state_d = StErr;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StFetch;
            opcode_q <= '0;
            func_q   <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                opcode_q <= bus.opcode;
                func_q   <= bus.lower_two;
            end
        end
    end

    // Outputs are forced low while rst is held so mem_read only rises after release.
    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        alu_op        = 1'b0;
        alu_src_1     = 1'b0;
        alu_src_2     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = RegDstI;
        alu_func      = '0;
        halt          = 1'b0;
        err           = 1'b0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    bus.mem_read = 1'b1;
                    // The word is valid only in the ready cycle, so IR/PC strobe with it.
                    ir_write     = bus.mem_ready;
                    pc_write     = bus.mem_ready;
                end
                StExec: begin
                    alu_op    = 1'b1;
                    alu_src_1 = (op_class == ClsAluImm) || (op_class == ClsLd) ||
                                (op_class == ClsSt);
                    alu_src_2 = (op_class == ClsRtype);
                    alu_func  = func_q;
                end
                StMem: begin
                    bus.mem_read  = (op_class == ClsLd);
                    bus.mem_write = (op_class == ClsSt);
                end
                StWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (op_class == ClsLd);
                    reg_dst    = (op_class == ClsRtype) ? RegDstR : RegDstI;
                end
                StHalt:  halt = 1'b1;
                StErr:   err  = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter OPCODE_W, default 5: opcode field width.
REQ-002 Parameter FUNC_W, default 2: function (lower_two) field width.
REQ-003 Parameter MEM_TIMEOUT, default 15: maximum mem_ready wait cycles before error, 1..255.
REQ-004 clk  in  1: single clock; all state updates on rising edge.
REQ-005 rst  in  1: asynchronous, active-high reset.
REQ-006 opcode  in  OPCODE_W: opcode bits of the instruction word returned by memory.
REQ-007 lower_two  in  FUNC_W: function bits of that word.
REQ-008 mem_ready  in  1: memory completion strobe for the current fetch, load or store.
REQ-009 ir_write, pc_write  out  1 each: latch instruction register; advance PC.
REQ-010 mem_read, mem_write  out  1 each: memory request, held until mem_ready.
REQ-011 alu_op, alu_src_1, alu_src_2, mem_to_reg, reg_write  out  1 each: datapath controls.
REQ-012 reg_dst  out  2: 00 I-format Rd, 01 R-format Rd, 10 R7.
REQ-013 state_o  out  3: current state encoding; halt  out  1; err  out  1.

Function
REQ-014 FSM states SHALL be: FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
REQ-015 FETCH: mem_read=1 each cycle; on mem_ready=1, ir_write=1, pc_write=1, opcode/lower_two captured internally, next state DECODE.
REQ-016 DECODE (1 cycle): captured opcode classified as HALT (00000), NOP (00001), ALU-imm (010xx), R-type (11011), ST (10000), LD (10001); any other opcode -> ERR.
REQ-017 DECODE transitions: HALT -> HALT; NOP -> FETCH; all others -> EXEC.
REQ-018 EXEC (1 cycle): alu_op=1; alu_src_1=1 for ALU-imm, LD, ST; alu_src_2=1 for R-type; next MEM for LD/ST, else WB.
REQ-019 MEM: mem_read=1 for LD, mem_write=1 for ST, held until mem_ready=1; then LD -> WB, ST -> FETCH.
REQ-020 WB (1 cycle): reg_write=1; mem_to_reg=1 for LD only; reg_dst=00 ALU-imm, 01 R-type, 00 LD; next FETCH.
REQ-021 lower_two SHALL be passed unmodified to the ALU decode; it SHALL NOT alter state sequencing.
REQ-022 All outputs SHALL be Moore functions of state and captured opcode; every output not driven active in a state SHALL be 0.
REQ-023 Wait counter SHALL clear on entry to FETCH/MEM, increment each cycle mem_ready=0, saturate at MEM_TIMEOUT; reaching MEM_TIMEOUT with mem_ready=0 -> ERR.
REQ-024 mem_ready=1 on the cycle the counter reaches MEM_TIMEOUT SHALL count as success; no ERR.
REQ-025 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-026 HALT, ERR SHALL be sticky until rst; halt=1 in HALT, err=1 in ERR, all other outputs 0.
REQ-027 Latency: ALU 4 cycles, LD 5, ST 4, NOP 2, with zero-wait memory.

Reset
REQ-028 rst=1 SHALL force FETCH, wait counter 0, captured opcode 0, all outputs 0 (mem_read rises after release), asynchronously, including mid-MEM or in HALT/ERR.
REQ-029 Outstanding memory requests SHALL be dropped on reset; the first post-reset mem_ready SHALL count only toward the new fetch.

Structure
REQ-030 Shared package multicycle_ctrl_pkg SHALL hold state encodings, opcode constants (HALT, NOP, ST, LD, R-type, ALU-imm prefix), reg_dst encodings.
REQ-031 Sub-module mem_wait_timer SHALL implement the saturating wait counter and timeout flag; the FSM SHALL remain in multicycle_ctrl.

Verification
REQ-032 ADDI (01000), mem_ready=1 every cycle -> FETCH,DECODE,EXEC,WB,FETCH; reg_write=1 in cycle 4 only, reg_dst=00.
REQ-033 LD (10001), mem_ready low 3 MEM cycles -> mem_read=1 4 cycles, then WB with mem_to_reg=1, reg_write=1.
REQ-034 ST (10000), MEM_TIMEOUT=4, mem_ready never asserted -> ERR after 4 MEM cycles, err=1, mem_write=0; remains until rst.
REQ-035 Opcode 00000 -> HALT, halt=1; further mem_ready pulses cause no change; rst -> FETCH, halt=0.
REQ-036 rst asserted mid-MEM of ST -> mem_write=0 same cycle, asynchronous; after release, FETCH with mem_read=1.
REQ-037 Illegal opcode 11111 -> ERR after DECODE; mem_ready exactly at timeout in FETCH -> DECODE, no err.
